dmem_arbiter: RTL and testbench

- Shares the single-port data memory (9-bit word address, 32-bit data, MemRead/MemWrite strobes, combinational Read_Data) between two requesters.
- Port 0 is the pipeline MEM stage. Port 1 is the program/data loader or debug port.
- Arbitrates, latches the winning request, drives the memory strobes for exactly one cycle, captures read data and returns a one-cycle acknowledge.
- Sits between the MEM stage / loader and the memory instance in the top level.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 48 ++++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM encoding,
// requester port indices and a small grant helper.
package dmem_arbiter_pkg;

   localparam int DMEM_ADDR_W = 9;
   localparam int DMEM_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the single-port memory bus.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface dmem_arbiter_if
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
);

   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;

   logic              busy;

   logic [ADDR_W-1:0] MemAddr;
   logic              MemRead;
   logic              MemWrite;
   logic [DATA_W-1:0] Write_Data;
   logic [DATA_W-1:0] Read_Data;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  Read_Data,
      output ack0, rdata0, ack1, rdata1, busy,
      output MemAddr, MemRead, MemWrite, Write_Data
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output Read_Data,
      input  ack0, rdata0, ack1, rdata1, busy,
      input  MemAddr, MemRead, MemWrite, Write_Data
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input arbiter with one-hot grant. Round-robin on ties unless FIXED_PRI is set,
// in which case port 0 always wins a tie.
module rr_arb2
   import dmem_arbiter_pkg::*;
#(
   parameter int FIXED_PRI = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       update_i,
   input  logic       upd_port_i,
   output logic [1:0] gnt_o
);

   localparam bit FIXED = (FIXED_PRI != 0);

   logic last_q;
   logic last_d;
   logic win;

   always_comb begin
      win = PORT_CPU;
      if (req_i == 2'b11) begin
         // last_q holds the port served most recently; the other one gets the tie
         win = (FIXED || (last_q == PORT_LDR)) ? PORT_CPU : PORT_LDR;
      end else if (req_i[1]) begin
         win = PORT_LDR;
      end
      gnt_o = (req_i != 2'b00) ? port_onehot(win) : 2'b00;
   end

   always_comb begin
      last_d = last_q;
      if (update_i) begin
         last_d = upd_port_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= PORT_LDR;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the MEM stage (port 0) and the
// loader/debug port (port 1); one access per three cycles, one-cycle ack.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_IDLE   | sample requests, latch the winner's fields, strobes low
//  ST_ACCESS | strobe the memory once with latched fields, capture read data
//  ST_RESP   | pulse the winner's ack, update the round-robin pointer
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = DMEM_ADDR_W,
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int FIXED_PRI = 0
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   state_e            state_q, state_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [1:0]        ack_q, ack_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              busy_q, busy_d;

   logic [1:0]        gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 #(
      .FIXED_PRI (FIXED_PRI)
   ) u_arb (
      .clk        (clk),
      .reset      (reset),
      .req_i      ({bus.req1, bus.req0}),
      .update_i   (state_q == ST_RESP),
      .upd_port_i (port_q),
      .gnt_o      (gnt)
   );

   always_comb begin
      sel_we    = gnt[1] ? bus.we1    : bus.we0;
      sel_addr  = gnt[1] ? bus.addr1  : bus.addr0;
      sel_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;
   end

   always_comb begin
      state_d  = state_q;
      port_d   = port_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mem_rd_d = mem_rd_q;
      mem_wr_d = mem_wr_q;
      ack_d    = ack_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      busy_d   = busy_q;
      case (state_q)
         ST_IDLE: begin
            ack_d = 2'b00;
            if (gnt != 2'b00) begin
               // strobes are set up here so they come straight off flops in ACCESS
               port_d   = gnt[1];
               we_d     = sel_we;
               addr_d   = sel_addr;
               wdata_d  = sel_wdata;
               mem_wr_d = sel_we;
               mem_rd_d = ~sel_we;
               busy_d   = 1'b1;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            if (!we_q) begin
               if (port_q == PORT_LDR) begin
                  rdata1_d = bus.Read_Data;
               end else begin
                  rdata0_d = bus.Read_Data;
               end
            end
            ack_d   = port_onehot(port_q);
            state_d = ST_RESP;
         end
         ST_RESP: begin
            ack_d   = 2'b00;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            ack_d    = 2'b00;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         port_q   <= PORT_CPU;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         ack_q    <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         port_q   <= port_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         ack_q    <= ack_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.MemAddr    = addr_q;
   assign bus.Write_Data = wdata_q;
   assign bus.MemRead    = mem_rd_q;
   assign bus.MemWrite   = mem_wr_q;
   assign bus.ack0       = ack_q[0];
   assign bus.ack1       = ack_q[1];
   assign bus.rdata0     = rdata0_q;
   assign bus.rdata1     = rdata1_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with
// its own memory model; directed sequences, a vector table and a random run.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW = 9;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0)) u_rr (
      .clk(clk), .reset(reset), .bus(bus0.slave));
   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1)) u_fix (
      .clk(clk), .reset(reset), .bus(bus1.slave));

   logic [DW-1:0] mem0 [512];
   logic [DW-1:0] mem1 [512];
   logic          init_req = 1'b0;

   function automatic logic [DW-1:0] init_val(input int i);
      logic [31:0] v;
      if (i == 1) return 32'hFE92_3F55;
      if (i == 4) return 32'h0FF0_0FF0;
      v = 32'(i);
      return (v * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 512; i++) begin
            mem0[i] <= init_val(i);
            mem1[i] <= init_val(i);
         end
      end else begin
         if (bus0.MemWrite) mem0[bus0.MemAddr] <= bus0.Write_Data;
         if (bus1.MemWrite) mem1[bus1.MemAddr] <= bus1.Write_Data;
      end
   end

   assign bus0.Read_Data = mem0[bus0.MemAddr];
   assign bus1.Read_Data = mem1[bus1.MemAddr];

   typedef struct {
      logic          ack0, ack1, busy, mrd, mwr;
      logic [AW-1:0] maddr;
      logic [DW-1:0] wdat, rdata0, rdata1;
   } obs_t;

   typedef struct {
      logic          port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rd;
   } vec_t;

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [DW-1:0] hold0, hold1;

   function automatic obs_t obs(input int dut);
      obs_t o;
      if (dut == 0) begin
         o.ack0 = bus0.ack0; o.ack1 = bus0.ack1; o.busy = bus0.busy;
         o.mrd = bus0.MemRead; o.mwr = bus0.MemWrite; o.maddr = bus0.MemAddr;
         o.wdat = bus0.Write_Data; o.rdata0 = bus0.rdata0; o.rdata1 = bus0.rdata1;
      end else begin
         o.ack0 = bus1.ack0; o.ack1 = bus1.ack1; o.busy = bus1.busy;
         o.mrd = bus1.MemRead; o.mwr = bus1.MemWrite; o.maddr = bus1.MemAddr;
         o.wdat = bus1.Write_Data; o.rdata0 = bus1.rdata0; o.rdata1 = bus1.rdata1;
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // e = {MemRead, MemWrite, ack0, ack1}
   task automatic chk_cycle(input string tag, input int dut, input logic [3:0] e);
      obs_t o;
      o = obs(dut);
      chk1({tag, " MemRead"},  o.mrd,  e[3]);
      chk1({tag, " MemWrite"}, o.mwr,  e[2]);
      chk1({tag, " ack0"},     o.ack0, e[1]);
      chk1({tag, " ack1"},     o.ack1, e[0]);
   endtask

   task automatic chk_reset_vals(input string tag, input int dut);
      obs_t o;
      o = obs(dut);
      chk_cycle(tag, dut, 4'b0000);
      chk1({tag, " busy"},       o.busy, 1'b0);
      chk({tag, " rdata0"},      o.rdata0, '0);
      chk({tag, " rdata1"},      o.rdata1, '0);
      chk({tag, " MemAddr"},     32'(o.maddr), '0);
      chk({tag, " Write_Data"},  o.wdat, '0);
   endtask

   task automatic set_req(input int dut, input logic port, input logic r, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (dut == 0 && port == 1'b0) begin
         bus0.req0 = r; bus0.we0 = we; bus0.addr0 = a; bus0.wdata0 = d;
      end else if (dut == 0) begin
         bus0.req1 = r; bus0.we1 = we; bus0.addr1 = a; bus0.wdata1 = d;
      end else if (port == 1'b0) begin
         bus1.req0 = r; bus1.we0 = we; bus1.addr0 = a; bus1.wdata0 = d;
      end else begin
         bus1.req1 = r; bus1.we1 = we; bus1.addr1 = a; bus1.wdata1 = d;
      end
   endtask

   task automatic clear_reqs();
      set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_req(0, 1'b1, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b1, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_reqs();
      @(negedge clk);
      reset = 1'b0;
      hold0 = '0;
      hold1 = '0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          tbl [9];
      vec_t          v;
      obs_t          o, o1;
      logic [3:0]    tie_e0 [12];
      logic [3:0]    tie_e1 [12];
      logic [3:0]    btb_e  [6];
      logic [3:0]    late_e [6];
      logic [DW-1:0] mref   [512];
      // random-run model state
      int            acc_cyc;
      logic          last, win, exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wd, rd_val;
      logic [DW-1:0] exp_rd [2];
      logic          pv [2];
      logic          pwe [2];
      logic [AW-1:0] paddr [2];
      logic [DW-1:0] pwd [2];
      logic          exp_acc, exp_ack;

      tie_e0 = '{4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 4'b0000,
                 4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
      tie_e1 = '{4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b0010, 4'b0000,
                 4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b0010, 4'b0000};
      btb_e  = '{4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b0010, 4'b0000};
      late_e = '{4'b0100, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 4'b0000};

      tbl[0] = '{1'b0, 1'b1, 9'h000, 32'h0002_C903, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 9'h000, 32'h0,         32'h0002_C903};
      tbl[2] = '{1'b1, 1'b1, 9'h1FF, 32'hDEAD_BEEF, 32'h0};
      tbl[3] = '{1'b0, 1'b0, 9'h1FF, 32'h0,         32'hDEAD_BEEF};
      tbl[4] = '{1'b0, 1'b1, 9'h008, 32'h1234_5678, 32'h0};
      tbl[5] = '{1'b1, 1'b0, 9'h008, 32'h0,         32'h1234_5678};
      tbl[6] = '{1'b1, 1'b0, 9'h004, 32'h0,         32'h0FF0_0FF0};
      tbl[7] = '{1'b0, 1'b0, 9'h001, 32'h0,         32'hFE92_3F55};
      tbl[8] = '{1'b0, 1'b0, 9'h100, 32'h0,         init_val(256)};

      // ---- power-on reset ----
      reset = 1'b1;
      clear_reqs();
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_vals("por dut0", 0);
      chk_reset_vals("por dut1", 1);
      reset = 1'b0;
      hold0 = '0;
      hold1 = '0;

      // ---- tie, both held: rr alternates from port 0, fixed always port 0 ----
      set_req(0, 1'b0, 1'b1, 1'b0, 9'h001, '0);
      set_req(0, 1'b1, 1'b1, 1'b0, 9'h004, '0);
      set_req(1, 1'b0, 1'b1, 1'b0, 9'h001, '0);
      set_req(1, 1'b1, 1'b1, 1'b0, 9'h004, '0);
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         o  = obs(0);
         o1 = obs(1);
         chk_cycle($sformatf("tie rr j%0d", j), 0, tie_e0[j-1]);
         chk_cycle($sformatf("tie fix j%0d", j), 1, tie_e1[j-1]);
         chk1($sformatf("tie rr busy j%0d", j), o.busy, (j % 3) != 0);
         chk1($sformatf("tie fix busy j%0d", j), o1.busy, (j % 3) != 0);
         if (o.ack0) chk("tie rr rdata0", o.rdata0, 32'hFE92_3F55);
         if (o.ack1) chk("tie rr rdata1", o.rdata1, 32'h0FF0_0FF0);
         if (o1.ack0) chk("tie fix rdata0", o1.rdata0, 32'hFE92_3F55);
         if (j == 11) clear_reqs();
      end
      chk("tie fix rdata1 never loaded", bus1.rdata1, '0);
      hold0 = 32'hFE92_3F55;
      hold1 = 32'h0FF0_0FF0;

      // ---- back-to-back port 0 with new address after ack ----
      set_req(0, 1'b0, 1'b1, 1'b0, 9'h004, '0);
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         o = obs(0);
         chk_cycle($sformatf("btb j%0d", j), 0, btb_e[j-1]);
         if (j == 1) chk("btb MemAddr 1", 32'(o.maddr), 32'h004);
         if (j == 4) chk("btb MemAddr 2", 32'(o.maddr), 32'h008);
         if (j == 2) begin
            chk("btb rdata0 1", o.rdata0, 32'h0FF0_0FF0);
            set_req(0, 1'b0, 1'b1, 1'b0, 9'h008, '0);
         end
         if (j == 5) begin
            chk("btb rdata0 2", o.rdata0, init_val(8));
            chk("btb rdata1 held", o.rdata1, hold1);
            set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
         end
      end
      hold0 = init_val(8);

      // ---- port 1 request raised during ACCESS waits for IDLE ----
      set_req(0, 1'b0, 1'b1, 1'b1, 9'h010, 32'hCAFE_F00D);
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         o = obs(0);
         chk_cycle($sformatf("late j%0d", j), 0, late_e[j-1]);
         if (j == 1) begin
            chk("late MemAddr w", 32'(o.maddr), 32'h010);
            chk("late Write_Data", o.wdat, 32'hCAFE_F00D);
            set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
            set_req(0, 1'b1, 1'b1, 1'b0, 9'h010, '0);
         end
         if (j == 2) chk("late rdata0 unchanged on write", o.rdata0, hold0);
         if (j == 4) chk("late MemAddr r", 32'(o.maddr), 32'h010);
         if (j == 5) begin
            chk("late rdata1", o.rdata1, 32'hCAFE_F00D);
            set_req(0, 1'b1, 1'b0, 1'b0, '0, '0);
         end
      end
      hold1 = 32'hCAFE_F00D;

      // ---- single-transaction vector table on the round-robin instance ----
      for (int i = 0; i < 9; i++) begin
         v = tbl[i];
         set_req(0, v.port, 1'b1, v.we, v.addr, v.wdata);
         @(negedge clk);
         o = obs(0);
         chk_cycle($sformatf("tbl[%0d] access", i), 0, {!v.we, v.we, 2'b00});
         chk($sformatf("tbl[%0d] MemAddr", i), 32'(o.maddr), 32'(v.addr));
         chk1($sformatf("tbl[%0d] busy", i), o.busy, 1'b1);
         if (v.we) chk($sformatf("tbl[%0d] Write_Data", i), o.wdat, v.wdata);
         set_req(0, v.port, 1'b0, 1'b0, '0, '0);
         @(negedge clk);
         o = obs(0);
         chk_cycle($sformatf("tbl[%0d] resp", i), 0, {2'b00, v.port == 1'b0, v.port == 1'b1});
         if (!v.we) begin
            if (v.port) hold1 = v.exp_rd;
            else        hold0 = v.exp_rd;
         end
         chk($sformatf("tbl[%0d] rdata0", i), o.rdata0, hold0);
         chk($sformatf("tbl[%0d] rdata1", i), o.rdata1, hold1);
         @(negedge clk);
         o = obs(0);
         chk_cycle($sformatf("tbl[%0d] idle", i), 0, 4'b0000);
         chk1($sformatf("tbl[%0d] idle busy", i), o.busy, 1'b0);
      end

      // ---- reset during ACCESS of a port-1 write; port 0 was served last ----
      set_req(0, 1'b1, 1'b1, 1'b1, 9'h0AA, 32'h55AA_55AA);
      @(negedge clk);
      chk_cycle("rst access", 0, 4'b0100);
      reset = 1'b1;
      set_req(0, 1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk_reset_vals("mid-access reset", 0);
      reset = 1'b0;
      hold0 = '0;
      hold1 = '0;
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         chk_cycle($sformatf("rst no ack j%0d", j), 0, 4'b0000);
      end
      set_req(0, 1'b0, 1'b1, 1'b0, 9'h001, '0);
      set_req(0, 1'b1, 1'b1, 1'b0, 9'h004, '0);
      @(negedge clk);
      chk_cycle("rst tie access", 0, 4'b1000);
      chk("rst tie MemAddr", 32'(bus0.MemAddr), 32'h001);
      @(negedge clk);
      chk_cycle("rst tie resp", 0, 4'b0010);
      chk("rst tie rdata0", bus0.rdata0, 32'hFE92_3F55);
      chk("rst tie rdata1", bus0.rdata1, '0);
      clear_reqs();
      @(negedge clk);

      // ---- random run against a transaction-level model ----
      @(negedge clk);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      for (int i = 0; i < 512; i++) mref[i] = init_val(i);
      do_reset();
      acc_cyc  = -100;
      last     = PORT_LDR;
      win      = PORT_CPU;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_wd   = '0;
      rd_val   = '0;
      for (int p = 0; p < 2; p++) begin
         exp_rd[p] = '0; pv[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = '0; pwd[p] = '0;
      end
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         o = obs(0);
         exp_acc = (k == acc_cyc);
         exp_ack = (k == acc_cyc + 1);
         if (exp_ack && !exp_we) exp_rd[win] = rd_val;
         chk1("rnd MemRead",  o.mrd,  exp_acc && !exp_we);
         chk1("rnd MemWrite", o.mwr,  exp_acc && exp_we);
         chk1("rnd ack0",     o.ack0, exp_ack && (win == 1'b0));
         chk1("rnd ack1",     o.ack1, exp_ack && (win == 1'b1));
         chk1("rnd busy",     o.busy, exp_acc || exp_ack);
         chk("rnd rdata0", o.rdata0, exp_rd[0]);
         chk("rnd rdata1", o.rdata1, exp_rd[1]);
         if (exp_acc) begin
            chk("rnd MemAddr", 32'(o.maddr), 32'(exp_addr));
            if (exp_we) chk("rnd Write_Data", o.wdat, exp_wd);
         end
         if (exp_ack) pv[win] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && $urandom_range(0, 2) == 0) begin
               pv[p]    = 1'b1;
               pwe[p]   = 1'($urandom_range(0, 1));
               paddr[p] = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7));
               pwd[p]   = $urandom;
            end
            set_req(0, 1'(p), pv[p], pwe[p], paddr[p], pwd[p]);
         end
         // arbiter is idle this cycle: the next edge samples whatever is pending
         if (k > acc_cyc + 1 && (pv[0] || pv[1])) begin
            if (pv[0] && pv[1]) win = (last == PORT_LDR) ? PORT_CPU : PORT_LDR;
            else                win = pv[1] ? PORT_LDR : PORT_CPU;
            acc_cyc  = k + 1;
            exp_we   = pwe[win];
            exp_addr = paddr[win];
            exp_wd   = pwd[win];
            if (exp_we) mref[exp_addr] = exp_wd;
            else        rd_val = mref[exp_addr];
            last = win;
         end
      end
      clear_reqs();
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
